// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver peripheral.
//   state_t      receive FSM states
//   *_OFF        register byte offsets inside the PS/2 window
//   STAT_*       STATUS register bit positions
package ps2_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CODE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] DATA_OFF   = 4'h0;
    localparam logic [ADDR_W-1:0] STATUS_OFF = 4'h4;
    localparam logic [ADDR_W-1:0] CTRL_OFF   = 4'h8;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_NEMPTY  = 1;
    localparam int unsigned STAT_FULL    = 2;
    localparam int unsigned STAT_PERR    = 3;
    localparam int unsigned STAT_FERR    = 4;
    localparam int unsigned STAT_OVF     = 5;
    localparam int unsigned STAT_CNT_LSB = 24;

    // PS/2 frames use odd parity over data plus parity bit
    function automatic logic odd_parity_ok(input logic [CODE_W-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_periph_if.sv
// Register bus between the address decoder (master) and the PS/2 peripheral (slave).
//   req_i, we_i, addr_i, wdata_i : request from the core
//   rdata_o                      : combinational read data from the peripheral
interface ps2_rx_periph_if;
    import ps2_pkg::*;

    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [DATA_W-1:0] rdata_o;

    modport master (output req_i, we_i, addr_i, wdata_i, input rdata_o);
    modport slave  (input req_i, we_i, addr_i, wdata_i, output rdata_o);

endinterface

// File: rtl/ps2_rx_fifo.sv
// Scan-code FIFO with push/pop/flush.
//   push, din      : write a code (dropped when full unless popping in the same cycle)
//   pop            : remove head (ignored when empty)
//   flush          : empty the FIFO, wins over push/pop
//   head_c, full_c, empty_c : combinational views of the stored state; count registered
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [CODE_W-1:0]        din,
    output logic [CODE_W-1:0]        head_c,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full_c,
    output logic                     empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [CODE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_pop_c;
    logic              do_push_c;

    assign empty_c   = (count == '0);
    assign full_c    = (count == CW'(DEPTH));
    assign do_pop_c  = pop & ~empty_c;
    assign do_push_c = push & (~full_c | do_pop_c);
    assign head_c    = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push_c) - CW'(do_pop_c);
        end
    end

    // Storage needs no reset; occupancy gates what is visible
    always_ff @(posedge clk) begin
        if (do_push_c && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_rx_periph.sv
// Memory-mapped PS/2 keyboard receiver.
//   clk_i, rstn_i         : system clock, async active-low reset (released synchronously)
//   bus                   : register bus slave (DATA/STATUS/CTRL)
//   ps2_clk_i, ps2_dat_i  : raw asynchronous PS/2 pins
//   irq_o                 : level interrupt while enabled and FIFO not empty
module ps2_rx_periph
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    ps2_rx_periph_if.slave        bus,
    input  logic                  ps2_clk_i,
    input  logic                  ps2_dat_i,
    output logic                  irq_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]        rst_sync;
    logic              rst_n;
    logic [2:0]        clk_sh;
    logic [1:0]        dat_sh;
    logic              fall_c;
    logic              dat_s;

    state_t            state, state_n;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic [CODE_W-1:0] shreg, shreg_n;
    logic              par_ok, par_ok_n;
    logic              push_c, ferr_set_c, perr_set_c;
    logic              busy_c, tmo_c;
    logic [TW-1:0]     tmo_cnt;

    logic              irq_en, ovf, ferr, perr;
    logic [ADDR_W-1:0] addr_c;
    logic              wr_ctrl_c, pop_c, flush_c, errclr_c, ovf_set_c;
    logic [CODE_W-1:0] head_c;
    logic [CW-1:0]     count;
    logic              full_c, empty_c;
    logic [DATA_W-1:0] rdata_c;
    logic              unused_ok;

    // Reset asserts immediately, releases on a clock edge
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rst_sync <= '0;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // Two-flop synchronisers plus one history flop on the clock for edge detect
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            clk_sh <= '1;
            dat_sh <= '1;
        end else begin
            clk_sh <= {clk_sh[1:0], ps2_clk_i};
            dat_sh <= {dat_sh[0], ps2_dat_i};
        end
    end
    assign fall_c = clk_sh[2] & ~clk_sh[1];
    assign dat_s  = dat_sh[1];

    assign busy_c = (state != IDLE);

    // Inactivity watchdog: restarts on each falling edge, runs only mid-frame
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)                tmo_cnt <= '0;
        else if (fall_c || !busy_c) tmo_cnt <= '0;
        else                       tmo_cnt <= tmo_cnt + TW'(1);
    end
    assign tmo_c = busy_c & ~fall_c & (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_ok  <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            par_ok  <= par_ok_n;
        end
    end

    // Frame deserialiser: start, 8 data LSB-first, odd parity, stop
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        par_ok_n   = par_ok;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;
        perr_set_c = 1'b0;
        if (tmo_c) begin
            state_n    = IDLE;
            ferr_set_c = 1'b1;
        end else if (fall_c) begin
            case (state)
                IDLE: begin
                    if (!dat_s) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    shreg_n   = {dat_s, shreg[CODE_W-1:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_ok_n = odd_parity_ok(shreg, dat_s);
                    state_n  = STOP;
                end
                STOP: begin
                    state_n    = IDLE;
                    perr_set_c = ~par_ok;
                    ferr_set_c = ~dat_s;
                    push_c     = par_ok & dat_s;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign addr_c    = {bus.addr_i[3:2], 2'b00};
    assign wr_ctrl_c = bus.req_i & bus.we_i & (addr_c == CTRL_OFF);
    assign pop_c     = bus.req_i & ~bus.we_i & (addr_c == DATA_OFF);
    assign flush_c   = wr_ctrl_c & bus.wdata_i[1];
    assign errclr_c  = wr_ctrl_c & bus.wdata_i[2];
    // A pop frees the slot a same-cycle push needs, so no overflow then
    assign ovf_set_c = push_c & full_c & ~pop_c;

    ps2_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk_i),
        .rst_n   (rst_n),
        .push    (push_c),
        .pop     (pop_c),
        .flush   (flush_c),
        .din     (shreg),
        .head_c  (head_c),
        .count   (count),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    // Control and sticky error flags; a new error beats a same-cycle clear
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= 1'b0;
            ovf    <= 1'b0;
            ferr   <= 1'b0;
            perr   <= 1'b0;
        end else begin
            if (wr_ctrl_c) irq_en <= bus.wdata_i[0];
            ovf  <= ovf_set_c  | (ovf  & ~errclr_c);
            ferr <= ferr_set_c | (ferr & ~errclr_c);
            perr <= perr_set_c | (perr & ~errclr_c);
        end
    end

    always_comb begin
        rdata_c = '0;
        case (addr_c)
            DATA_OFF:   rdata_c[CODE_W-1:0] = empty_c ? '0 : head_c;
            STATUS_OFF: begin
                rdata_c[STAT_BUSY]   = busy_c;
                rdata_c[STAT_NEMPTY] = ~empty_c;
                rdata_c[STAT_FULL]   = full_c;
                rdata_c[STAT_PERR]   = perr;
                rdata_c[STAT_FERR]   = ferr;
                rdata_c[STAT_OVF]    = ovf;
                rdata_c[STAT_CNT_LSB +: 8] = 8'(count);
            end
            CTRL_OFF:   rdata_c[0] = irq_en;
            default:    rdata_c = '0;
        endcase
    end

    assign bus.rdata_o = rdata_c;
    assign irq_o       = irq_en & ~empty_c;

    assign unused_ok = ^{bus.wdata_i[DATA_W-1:3], bus.addr_i[1:0]};

endmodule
